// File: rtl/rgb2grayscale_pipe.sv
// Three-stage RGB-to-luma converter with valid/accept flow control, four conversion modes and a frame-start sideband.
// Define RGB2GRAY_ROUND_EN to round half-up before the >>8 in modes 0 and 1; otherwise the sum is truncated.
module rgb2grayscale_pipe #(
   parameter int R_W    = 5,
   parameter int G_W    = 6,
   parameter int B_W    = 5,
   parameter int COEF_R = 77,
   parameter int COEF_G = 150,
   parameter int COEF_B = 29,
   parameter int OUT_W  = 8
) (
   input  logic                     iClk,
   input  logic                     iReset,
   input  logic                     iInput_ready,
   output logic                     oInput_accept,
   input  logic [R_W+G_W+B_W-1:0]   iRGB,
   input  logic [1:0]               iMode,
   input  logic                     iFrame_start,
   output logic                     oOutput_ready,
   input  logic                     iOutput_accept,
   output logic [OUT_W-1:0]         oY,
   output logic                     oFrame_start
);

   localparam int IN_W = R_W + G_W + B_W;

   // Widen a W-bit channel to 8 bits by repeating its bit pattern from the MSB down.
   function automatic logic [7:0] expand(input logic [7:0] v, input int w);
      logic [7:0] e;
      e = '0;
      for (int i = 0; i < 8; i++) e[7-i] = v[w-1-(i%w)];
      return e;
   endfunction

   logic en;
   logic [7:0] r8, g8, b8;
   logic [7:0] wr, wg, wb;
   logic [15:0] pr_d, pg_d, pb_d;
   logic [7:0] byp_d;

   // S1 state
   logic v1_q, sof1_q;
   logic [1:0] mode1_q;
   logic [15:0] pr_q, pg_q, pb_q;
   logic [7:0] byp1_q;

   // S2 state
   logic v2_q, sof2_q;
   logic [1:0] mode2_q;
   logic [17:0] sum_d, sum_q;
   logic [7:0] byp2_q;

   // S3 state
   logic out_valid_q, sof_q;
   logic [OUT_W-1:0] y_q, y_d;
   logic [17:0] sum_rnd;
   logic [9:0] shifted;
   logic [7:0] y8;

   assign en            = !out_valid_q || iOutput_accept;
   assign oInput_accept = en;
   assign oOutput_ready = out_valid_q;
   assign oY            = y_q;
   assign oFrame_start  = sof_q;

   always_comb begin
      r8 = expand(8'(iRGB[IN_W-1 -: R_W]), R_W);
      g8 = expand(8'(iRGB[G_W+B_W-1 -: G_W]), G_W);
      b8 = expand(8'(iRGB[B_W-1:0]), B_W);
      wr = 8'(COEF_R);
      wg = 8'(COEF_G);
      wb = 8'(COEF_B);
      if (iMode == 2'd1) begin
         wr = 8'd85;
         wg = 8'd86;
         wb = 8'd85;
      end
      pr_d = 16'(r8) * 16'(wr);
      pg_d = 16'(g8) * 16'(wg);
      pb_d = 16'(b8) * 16'(wb);
      byp_d = g8;
      if (iMode == 2'd2) begin
         byp_d = (r8 > g8) ? r8 : g8;
         if (b8 > byp_d) byp_d = b8;
      end
   end

   assign sum_d = 18'(pr_q) + 18'(pg_q) + 18'(pb_q);

`ifdef RGB2GRAY_ROUND_EN
   assign sum_rnd = sum_q + 18'd128;
`else
   assign sum_rnd = sum_q;
`endif

   always_comb begin
      shifted = sum_rnd[17:8];
      y8      = (|shifted[9:8]) ? 8'hFF : shifted[7:0];
      if (mode2_q[1]) y8 = byp2_q;
      y_d = y8[7 -: OUT_W];
   end

   // Control and output registers: the only state that reset must clear.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         sof_q       <= 1'b0;
      end else if (en) begin
         v1_q        <= iInput_ready;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         y_q         <= y_d;
         sof_q       <= sof2_q & v2_q;
      end
   end

   // NOTE: datapath registers carry no reset; their contents are qualified by the valid bits above.
   always_ff @(posedge iClk) begin
      if (en) begin
         sof1_q  <= iFrame_start;
         mode1_q <= iMode;
         pr_q    <= pr_d;
         pg_q    <= pg_d;
         pb_q    <= pb_d;
         byp1_q  <= byp_d;
         sof2_q  <= sof1_q;
         mode2_q <= mode1_q;
         sum_q   <= sum_d;
         byp2_q  <= byp1_q;
      end
   end

endmodule

// File: tb/tb_rgb2grayscale_pipe.sv
// Scoreboard bench for rgb2grayscale_pipe: the driver queues hand-computed luma, the monitor pops on each output transfer.
// Extra instances cover saturating coefficients and a 4-bit output width.
module tb_rgb2grayscale_pipe;

`ifdef RGB2GRAY_ROUND_EN
   localparam logic [7:0] Y_F800 = 8'd77, Y_001F = 8'd29, Y_F800_M1 = 8'd85, Y_07E0_M1 = 8'd86;
`else
   localparam logic [7:0] Y_F800 = 8'd76, Y_001F = 8'd28, Y_F800_M1 = 8'd84, Y_07E0_M1 = 8'd85;
`endif

   logic clk = 1'b0;
   logic rst, in_ready, sof_in, out_accept;
   logic [15:0] rgb;
   logic [1:0] mode;
   logic in_accept, out_ready, sof_out;
   logic [7:0] y;
   logic sat_in_accept, sat_ready, sat_sof;
   logic [7:0] sat_y;
   logic w4_in_accept, w4_ready, w4_sof;
   logic [3:0] w4_y;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit lat_en = 1'b1;

   typedef struct {
      logic [7:0] y;
      logic       sof;
      int         cyc;
      bit         lat;
      bit         alt;
      logic [7:0] y_sat;
      logic [3:0] y_w4;
   } exp_t;
   exp_t sb[$];

   rgb2grayscale_pipe dut (
      .iClk(clk), .iReset(rst), .iInput_ready(in_ready), .oInput_accept(in_accept),
      .iRGB(rgb), .iMode(mode), .iFrame_start(sof_in), .oOutput_ready(out_ready),
      .iOutput_accept(out_accept), .oY(y), .oFrame_start(sof_out));

   rgb2grayscale_pipe #(.COEF_R(200), .COEF_G(200), .COEF_B(200)) u_sat (
      .iClk(clk), .iReset(rst), .iInput_ready(in_ready), .oInput_accept(sat_in_accept),
      .iRGB(rgb), .iMode(mode), .iFrame_start(sof_in), .oOutput_ready(sat_ready),
      .iOutput_accept(out_accept), .oY(sat_y), .oFrame_start(sat_sof));

   rgb2grayscale_pipe #(.OUT_W(4)) u_w4 (
      .iClk(clk), .iReset(rst), .iInput_ready(in_ready), .oInput_accept(w4_in_accept),
      .iRGB(rgb), .iMode(mode), .iFrame_start(sof_in), .oOutput_ready(w4_ready),
      .iOutput_accept(out_accept), .oY(w4_y), .oFrame_start(w4_sof));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Present one pixel until it transfers; caller is at posedge+1 on entry and exit.
   task automatic send(input logic [15:0] p, input logic [1:0] m, input logic s, input logic [7:0] ey,
                       input bit push = 1'b1, input bit alt = 1'b0,
                       input logic [7:0] es = 8'd0, input logic [3:0] e4 = 4'd0);
      exp_t e;
      bit done;
      done = 1'b0;
      rgb = p; mode = m; sof_in = s; in_ready = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_accept) begin
            if (push) begin
               e.y = ey; e.sof = s; e.cyc = cyc; e.lat = lat_en;
               e.alt = alt; e.y_sat = es; e.y_w4 = e4;
               sb.push_back(e);
            end
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      in_ready = 1'b0;
      sof_in = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Monitor: checks each presented output, stall stability, and pops on transfer.
   bit hold = 1'b0;
   logic [7:0] held_y;
   logic held_sof;
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("stall_ready", 32'(out_ready), 32'd1);
            check("stall_hold_y", 32'(y), 32'(held_y));
            check("stall_hold_sof", 32'(sof_out), 32'(held_sof));
         end
         if (out_ready) begin
            if (!out_accept) check("stall_in_accept", 32'(in_accept), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got y=%0d with empty scoreboard (t=%0t)", y, $time);
            end else begin
               if (!hold && sb[0].lat) check("latency", 32'(cyc - sb[0].cyc), 32'd3);
               if (out_accept) begin
                  exp_t e;
                  e = sb.pop_front();
                  check("luma", 32'(y), 32'(e.y));
                  check("frame_start", 32'(sof_out), 32'(e.sof));
                  if (e.alt) begin
                     check("sat_luma", 32'(sat_y), 32'(e.y_sat));
                     check("w4_luma", 32'(w4_y), 32'(e.y_w4));
                  end
               end
            end
            hold = !out_accept;
            held_y = y;
            held_sof = sof_out;
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1; in_ready = 1'b0; rgb = '0; mode = '0; sof_in = 1'b0; out_accept = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      check("reset_ready", 32'(out_ready), 32'd0);
      check("reset_y", 32'(y), 32'd0);
      check("reset_sof", 32'(sof_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("accept_after_reset", 32'(in_accept), 32'd1);
      @(posedge clk); #1;

      // Mode 0 primaries, back to back, with saturating and 4-bit instances alongside.
      send(16'hFFFF, 2'd0, 1'b0, 8'd255, 1'b1, 1'b1, 8'd255, 4'hF);
      send(16'hF800, 2'd0, 1'b0, Y_F800, 1'b1, 1'b1, 8'd199, 4'd4);
      send(16'h07E0, 2'd0, 1'b0, 8'd149, 1'b1, 1'b1, 8'd199, 4'd9);
      send(16'h001F, 2'd0, 1'b0, Y_001F, 1'b1, 1'b1, 8'd199, 4'd1);
      idle(2);

      // Mode switched every pixel.
      send(16'h8410, 2'd2, 1'b0, 8'd132, 1'b1, 1'b1, 8'd132, 4'd8);
      send(16'h8410, 2'd3, 1'b0, 8'd130);
      send(16'hFFFF, 2'd1, 1'b0, 8'd255);
      send(16'h07E0, 2'd3, 1'b0, 8'd255, 1'b1, 1'b1, 8'd255, 4'hF);
      send(16'hF800, 2'd1, 1'b0, Y_F800_M1);
      send(16'h07E0, 2'd1, 1'b0, Y_07E0_M1);
      send(16'h07E0, 2'd2, 1'b0, 8'd255);
      send(16'h001F, 2'd3, 1'b0, 8'd0);
      idle(4);

      // Frame-start on the first pixel of a 4-pixel burst.
      send(16'h0020, 2'd3, 1'b1, 8'd4);
      send(16'h0200, 2'd3, 1'b0, 8'd65);
      send(16'h0100, 2'd3, 1'b0, 8'd32);
      send(16'h07C0, 2'd3, 1'b0, 8'd251);
      idle(4);

      // Back-pressure: 5-cycle stall in the middle of an 8-pixel stream.
      lat_en = 1'b0;
      fork
         begin
            send(16'h0020, 2'd3, 1'b0, 8'd4);
            send(16'h0200, 2'd3, 1'b0, 8'd65);
            send(16'h0100, 2'd3, 1'b0, 8'd32);
            send(16'h07C0, 2'd3, 1'b0, 8'd251);
            send(16'h0420, 2'd3, 1'b0, 8'd134);
            send(16'h8410, 2'd2, 1'b0, 8'd132);
            send(16'hFFFF, 2'd3, 1'b0, 8'd255);
            send(16'h0000, 2'd2, 1'b0, 8'd0);
            idle(1);
         end
         begin
            repeat (3) begin @(posedge clk); #1; end
            out_accept = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            out_accept = 1'b1;
         end
      join
      idle(6);
      lat_en = 1'b1;

      // Reset with two pixels in flight and a third offered during reset.
      send(16'hFFFF, 2'd3, 1'b1, 8'd0, 1'b0);
      send(16'h8410, 2'd2, 1'b0, 8'd0, 1'b0);
      rst = 1'b1;
      rgb = 16'h07E0; mode = 2'd3; in_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_ready = 1'b0;
      @(negedge clk);
      check("flush_ready", 32'(out_ready), 32'd0);
      check("flush_y", 32'(y), 32'd0);
      check("flush_sof", 32'(sof_out), 32'd0);
      check("flush_accept", 32'(in_accept), 32'd1);
      @(posedge clk); #1;
      send(16'h8410, 2'd3, 1'b1, 8'd130);
      idle(2);

      for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clk);
      idle(3);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
